timer_sched: RTL
================

Name: timer_sched

Overview:
- Four-channel seconds-countdown scheduler driven from the 50 MHz board clock.
- Contains one shared prescaler that produces a 1 Hz single-cycle tick enable. No derived clock is generated.
- On each tick, a round-robin sweep services the four channels through one shared decrementer.
- Sits between the host/control logic and the display/alarm logic. Provides start/stop/load per channel and reports expiry pulses.

Parameters:
- DIV, 50000000, prescaler period in clk_50MHz cycles; one tick per DIV cycles; legal range DIV >= 8.
- CNT_W, 8, width of each channel's seconds counter.

Ports:
- clk_50MHz  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high; clears every register.
- enable  in  1  prescaler run; low freezes the prescaler count (no ticks).
- load  in  1  write load_val into channel load_ch this cycle.
- load_ch  in  2  target channel for load.
- load_val  in  CNT_W  seconds value to load.
- start  in  4  per-channel start strobe (bit i = channel i).
- stop  in  4  per-channel stop strobe.
- tick_1hz  out  1  one-cycle strobe, once per DIV enabled cycles.
- busy  out  1  high while a sweep is in progress.
- running  out  4  per-channel run flag.
- expired  out  4  one-cycle pulse per channel on reaching terminal count.
- remain  out  4*CNT_W  channel counters, concatenated; channel i at bits [i*CNT_W +: CNT_W].

Behaviour:
- Reset (async): prescaler count=0, state=IDLE, idx=0, all remain=0, running=0, expired=0, tick_1hz=0, busy=0. A reset mid-sweep abandons the sweep; no expiry pulse is emitted.
- Prescaler:
  - When enable=1, count increments each cycle.
  - At count==DIV-1, tick_1hz=1 for that cycle and count wraps to 0.
  - When enable=0, count holds and tick_1hz=0.
  - Re-asserting enable resumes from the held count.
- FSM states: IDLE, SWEEP.
  - IDLE: tick_1hz=1 -> SWEEP, idx=0.
  - SWEEP: service channel idx each cycle; idx increments; after idx=3 -> IDLE.
  - busy=1 exactly in SWEEP, so each sweep lasts 4 cycles.
  - DIV >= 8 guarantees no tick arrives during a sweep.
- Timing: for a tick in cycle T, channel k is serviced in cycle T+1+k. Its updated remain and expired pulse are visible in cycle T+2+k.
- Service of channel k, when running[k]=1:
  - remain>1: remain <= remain-1.
  - remain==1: remain <= 0, running[k] <= 0, expired[k] pulses 1 cycle.
  - remain==0 (started with zero): remain stays 0, running[k] <= 0, expired[k] pulses.
  - If running[k]=0, the service is a no-op.
- Host operations (take effect at the clock edge):
  - start[i] sets running[i].
  - stop[i] clears running[i].
  - stop[i] and start[i] asserted together: stop wins.
  - load sets remain[load_ch] <= load_val and leaves running unchanged.
- Collisions with the channel being serviced in the same cycle (host wins; that channel is skipped this sweep):
  - load: the loaded value is kept, no decrement, no expiry.
  - stop: the channel ends stopped with remain unchanged and no expiry.
  - start on a stopped channel: the channel ends running and is not decremented until the next sweep.
- Arithmetic: the decrement never wraps, because 0 is terminal. remain is unsigned CNT_W.
- Channels not selected by idx are unaffected by service.

Test Plan:
- Reset mid-operation (DIV=10): load ch0=3, start ch0, run 15 cycles, pulse reset -> all outputs 0 immediately; no expired pulse for 40 cycles afterwards.
- Basic countdown (DIV=10): load ch2=3, start[2] -> remain ch2 steps 3,2,1,0 at the sweep after ticks 1, 2, 3. expired[2] pulses once, 2+2 cycles after the third tick. running[2]=0 afterwards.
- Sweep timing (DIV=10): all channels loaded to 5 and started -> tick in cycle T; busy high T+1..T+4. ch0..ch3 read 4 in cycles T+2..T+5 respectively.
- Zero start, stop/start (DIV=10):
  - Load ch1=0, start -> expired[1] pulses at the first sweep.
  - Assert stop[1] and start[1] together -> running[1]=0.
- enable gating (DIV=10): enable low for 25 cycles mid-count -> no tick; tick resumes after the remaining cycles, for a total of 10 enabled cycles.
- Collisions (DIV=10):
  - load ch3=9 in the cycle ch3 is serviced -> remain ch3=9, no decrement.
  - stop[0] in the cycle ch0 is serviced with remain=1 -> no expired pulse, remain stays 1.

Source files
------------

// File: rtl/timer_sched.sv
// ---------------------------------------------------------------------------
// timer_sched : four-channel seconds countdown, shared 1 Hz prescaler and
//               round-robin shared decrementer
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module timer_sched #(
  parameter int DIV   = 50000000,
  parameter int CNT_W = 8
) (
  input  logic               clk_50MHz,
  input  logic               reset,
  input  logic               enable,
  input  logic               load,
  input  logic [1:0]         load_ch,
  input  logic [CNT_W-1:0]   load_val,
  input  logic [3:0]         start,
  input  logic [3:0]         stop,
  output logic               tick_1hz,
  output logic               busy,
  output logic [3:0]         running,
  output logic [3:0]         expired,
  output logic [4*CNT_W-1:0] remain
);

  localparam int              c_PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_PW-1:0] c_LAST = c_PW'(DIV - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_idx;
  logic [1:0]       w_idx_nxt;
  logic [c_PW-1:0]  r_count;
  logic [CNT_W-1:0] r_remain [4];
  logic             r_run    [4];
  logic             r_exp    [4];

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= (r_count == c_LAST) ? '0 : r_count + 1'b1;
    end
  end

  assign tick_1hz = enable && (r_count == c_LAST);

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_idx   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    busy        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (tick_1hz) begin
          w_state_nxt = ST_SWEEP;
          w_idx_nxt   = 2'd0;
        end
      end
      ST_SWEEP: begin
        busy      = 1'b1;
        w_idx_nxt = r_idx + 2'd1;
        if (r_idx == 2'd3) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  for (genvar i = 0; i < 4; i++) begin : g_ch
    logic w_load_hit;
    logic w_svc;
    logic w_last;

    assign w_load_hit = load && (load_ch == 2'(i));
    // Any host operation on this channel pre-empts its service slot.
    assign w_svc  = busy && (r_idx == 2'(i)) && r_run[i]
                    && !(w_load_hit || start[i] || stop[i]);
    assign w_last = (r_remain[i] <= CNT_W'(1));

    always_ff @(posedge clk_50MHz or posedge reset) begin
      if (reset) begin
        r_remain[i] <= '0;
        r_run[i]    <= 1'b0;
        r_exp[i]    <= 1'b0;
      end else begin
        r_exp[i] <= w_svc && w_last;

        if (stop[i]) begin
          r_run[i] <= 1'b0;
        end else if (start[i]) begin
          r_run[i] <= 1'b1;
        end else if (w_svc && w_last) begin
          r_run[i] <= 1'b0;
        end

        if (w_load_hit) begin
          r_remain[i] <= load_val;
        end else if (w_svc) begin
          r_remain[i] <= w_last ? '0 : r_remain[i] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    running = '0;
    expired = '0;
    remain  = '0;
    for (int i = 0; i < 4; i++) begin
      running[i]               = r_run[i];
      expired[i]               = r_exp[i];
      remain[i*CNT_W +: CNT_W] = r_remain[i];
    end
  end

endmodule

`default_nettype wire
